mem_wb: RTL and testbench
=========================

# mem_wb

Pipeline register and load-result formatter between the MEM stage and the register file of the 5-stage MIPS core. It captures the MEM-stage result and the raw data-RAM read word each cycle. It applies the byte/halfword extraction and sign/zero extension that loads require. It drives the register-file write port (`write_en`/`write_addr`/`write_data`) for one cycle per retired instruction, honouring stall, flush and misaligned-load suppression.

## Interface
- No parameters.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `stall_mem`  in  1  MEM stage held by the controller
- `stall_wb`  in  1  WB stage held by the controller
- `flush`  in  1  kill the instruction entering WB
- `mem_valid`  in  1  MEM holds a real instruction
- `mem_wreg`  in  1  instruction writes a GPR
- `mem_wd`  in  5  destination register
- `mem_wdata`  in  32  ALU/move result for non-loads
- `mem_is_load`  in  1  instruction is a load
- `mem_load_op`  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; others reserved
- `mem_addr_lo`  in  2  effective address bits [1:0]
- `mem_rdata`  in  32  data-RAM read word, valid in the same cycle as the MEM inputs
- `wb_wreg`  out  1  to regfile `write_en`
- `wb_wd`  out  5  to regfile `write_addr`
- `wb_wdata`  out  32  to regfile `write_data`
- `wb_ade`  out  1  misaligned/reserved load reached WB (one-cycle pulse)
- `wb_retire_cnt`  out  32  count of instructions that reached WB

## Operation
- Update priority on each rising `clk`:
  - `rst`: all outputs go to 0.
  - `flush`: bubble. `wb_wreg`=0, `wb_wd`=0, `wb_wdata`=0, `wb_ade`=0. Counter holds.
  - `stall_mem`=1 and `stall_wb`=0: bubble, same values as flush.
  - `stall_mem`=1 and `stall_wb`=1: all outputs hold. `wb_ade` is forced 0 so the pulse never repeats.
  - Otherwise: capture. `stall_wb`=1 with `stall_mem`=0 is illegal from the controller and is treated as capture.
- Capture when `mem_valid`=0: produces a bubble.
- Capture for a non-load: `wb_wreg`=`mem_wreg`, `wb_wd`=`mem_wd`, `wb_wdata`=`mem_wdata`.
- Capture for a load (big-endian; byte 0 = `mem_rdata[31:24]`):
  - LW: needs `addr_lo`=00. Data = `mem_rdata`.
  - LH/LHU: needs `addr_lo[0]`=0. `addr_lo[1]`=0 selects [31:16], =1 selects [15:0]. LH sign-extends, LHU zero-extends.
  - LB/LBU: `addr_lo` 00/01/10/11 selects [31:24]/[23:16]/[15:8]/[7:0]. LB sign-extends, LBU zero-extends.
  - Misaligned address or reserved `mem_load_op`: `wb_wreg`=0, `wb_wdata`=0, `wb_ade`=1, `wb_wd`=`mem_wd`.
- `wb_wd`=0 is passed through unchanged. The register file ignores writes to r0.
- `wb_retire_cnt`:
  - Increments by 1 on every capture with `mem_valid`=1, including suppressed loads.
  - Wraps 0xFFFFFFFF→0.
  - Bubbles, holds and flushes do not count.

## Timing
- Latency is 1 cycle: MEM inputs sampled at edge N appear on the outputs after edge N.
- The register file writes at edge N+1. During cycle N→N+1 its read bypass returns `wb_wdata` to ID combinationally.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset values: `wb_wreg`=0, `wb_wd`=0, `wb_wdata`=0, `wb_ade`=0, `wb_retire_cnt`=0.
- Reset asserted mid-stall clears state at the next edge. The first capture occurs at the first edge with `rst`=0.
- `flush` and `stall_*` asserted together: flush wins.

## Test plan
- Reset, then capture non-load `mem_wreg`=1, `mem_wd`=5, `mem_wdata`=0x1234_5678 → next cycle `wb_wreg`=1, `wb_wd`=5, `wb_wdata`=0x12345678, `wb_retire_cnt`=1.
- Loads with `mem_rdata`=0x80FF_7F01:
  - LB, addr 00 → 0xFFFFFF80.
  - LBU, addr 00 → 0x00000080.
  - LB, addr 10 → 0x0000007F.
  - LH, addr 10 → 0x00007F01.
  - LHU, addr 00 → 0x000080FF.
  - LW → 0x80FF7F01.
- LW at addr 01 and LH at addr 11 → `wb_wreg`=0, `wb_ade`=1 for exactly one cycle, counter increments. `mem_load_op`=111 gives the same response.
- `stall_mem`=1, `stall_wb`=0 for 1 cycle → bubble (`wb_wreg`=0). Then both stalled for 3 cycles → outputs frozen at the bubble, counter unchanged.
- Held valid write, then `flush`=1 together with `stall_mem`=1 → bubble. Then `rst`=1 during a hold → all outputs 0 after one edge.
- Preload counter to 0xFFFFFFFE via 0xFFFFFFFE captures (or a forced value), then 2 valid captures → `wb_retire_cnt` reads 0xFFFFFFFF, then 0x00000000.

Source files
------------

// File: rtl/mem_wb_if.sv
// MEM-to-WB bundle: MEM-stage result, data-RAM read word and controller
// stall/flush in, register-file write port and retire bookkeeping out.
interface mem_wb_if;
  logic        stall_mem;
  logic        stall_wb;
  logic        flush;
  logic        mem_valid;
  logic        mem_wreg;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata;
  logic        mem_is_load;
  logic [2:0]  mem_load_op;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_rdata;
  logic        wb_wreg;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata;
  logic        wb_ade;
  logic [31:0] wb_retire_cnt;

  // The master side is the MEM stage/controller, which drives the inputs.
  modport master (
    output stall_mem, stall_wb, flush,
    output mem_valid, mem_wreg, mem_wd, mem_wdata,
    output mem_is_load, mem_load_op, mem_addr_lo, mem_rdata,
    input  wb_wreg, wb_wd, wb_wdata, wb_ade, wb_retire_cnt
  );

  modport slave (
    input  stall_mem, stall_wb, flush,
    input  mem_valid, mem_wreg, mem_wd, mem_wdata,
    input  mem_is_load, mem_load_op, mem_addr_lo, mem_rdata,
    output wb_wreg, wb_wd, wb_wdata, wb_ade, wb_retire_cnt
  );
endinterface

// File: rtl/mem_wb.sv
// MEM/WB pipeline register with big-endian load formatting and misaligned
// load suppression; drives the register-file write port one cycle later.
module mem_wb (
  input  logic   clk,
  input  logic   rst,
  mem_wb_if.slave bus
);

  typedef enum logic [1:0] {
    UPD_CAPTURE,
    UPD_BUBBLE,
    UPD_HOLD
  } upd_e;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100
  } load_op_e;

  logic        wreg_q;
  logic [4:0]  wd_q;
  logic [31:0] wdata_q;
  logic        ade_q;
  logic [31:0] retire_cnt;

  logic        wreg_d;
  logic [4:0]  wd_d;
  logic [31:0] wdata_d;
  logic        ade_d;
  logic [31:0] retire_cnt_d;

  upd_e        upd;
  logic        load_ok;
  logic [31:0] load_data;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Flush beats every stall; a lone WB stall is treated as a capture.
  always_comb begin
    upd = UPD_CAPTURE;
    if (bus.flush)
      upd = UPD_BUBBLE;
    else if (bus.stall_mem && !bus.stall_wb)
      upd = UPD_BUBBLE;
    else if (bus.stall_mem && bus.stall_wb)
      upd = UPD_HOLD;
  end

  always_comb begin
    half_sel = bus.mem_addr_lo[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
    byte_sel = bus.mem_rdata[31:24];
    case (bus.mem_addr_lo)
      2'b00:   byte_sel = bus.mem_rdata[31:24];
      2'b01:   byte_sel = bus.mem_rdata[23:16];
      2'b10:   byte_sel = bus.mem_rdata[15:8];
      default: byte_sel = bus.mem_rdata[7:0];
    endcase
  end

  // Reserved opcodes fall to the default arm and are reported like misalignment.
  always_comb begin
    load_ok   = 1'b0;
    load_data = 32'd0;
    case (load_op_e'(bus.mem_load_op))
      OP_LW: begin
        load_ok   = (bus.mem_addr_lo == 2'b00);
        load_data = bus.mem_rdata;
      end
      OP_LH: begin
        load_ok   = !bus.mem_addr_lo[0];
        load_data = {{16{half_sel[15]}}, half_sel};
      end
      OP_LHU: begin
        load_ok   = !bus.mem_addr_lo[0];
        load_data = {16'd0, half_sel};
      end
      OP_LB: begin
        load_ok   = 1'b1;
        load_data = {{24{byte_sel[7]}}, byte_sel};
      end
      OP_LBU: begin
        load_ok   = 1'b1;
        load_data = {24'd0, byte_sel};
      end
      default: begin
        load_ok   = 1'b0;
        load_data = 32'd0;
      end
    endcase
  end

  always_comb begin
    wreg_d       = wreg_q;
    wd_d         = wd_q;
    wdata_d      = wdata_q;
    ade_d        = 1'b0;
    retire_cnt_d = retire_cnt;
    case (upd)
      UPD_BUBBLE: begin
        wreg_d  = 1'b0;
        wd_d    = 5'd0;
        wdata_d = 32'd0;
      end
      UPD_HOLD: begin
        ade_d = 1'b0;
      end
      default: begin
        if (!bus.mem_valid) begin
          wreg_d  = 1'b0;
          wd_d    = 5'd0;
          wdata_d = 32'd0;
        end else begin
          retire_cnt_d = retire_cnt + 32'd1;
          wd_d         = bus.mem_wd;
          if (!bus.mem_is_load) begin
            wreg_d  = bus.mem_wreg;
            wdata_d = bus.mem_wdata;
          end else if (load_ok) begin
            wreg_d  = bus.mem_wreg;
            wdata_d = load_data;
          end else begin
            wreg_d  = 1'b0;
            wdata_d = 32'd0;
            ade_d   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wreg_q     <= 1'b0;
      wd_q       <= 5'd0;
      wdata_q    <= 32'd0;
      ade_q      <= 1'b0;
      retire_cnt <= 32'd0;
    end else begin
      wreg_q     <= wreg_d;
      wd_q       <= wd_d;
      wdata_q    <= wdata_d;
      ade_q      <= ade_d;
      retire_cnt <= retire_cnt_d;
    end
  end

  assign bus.wb_wreg       = wreg_q;
  assign bus.wb_wd         = wd_q;
  assign bus.wb_wdata      = wdata_q;
  assign bus.wb_ade        = ade_q;
  assign bus.wb_retire_cnt = retire_cnt;

endmodule

// File: tb/tb_mem_wb.sv
// Self-checking bench for mem_wb: directed steps followed by random traffic,
// compared against a byte-lane reference model of the MEM/WB rules.
module tb_mem_wb;

  logic clk;
  logic rst;

  mem_wb_if bus_if ();

  mem_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vectors;
  int          n_miss;
  logic        exp_wreg;
  logic [4:0]  exp_wd;
  logic [31:0] exp_wdata;
  logic        exp_ade;
  logic [31:0] exp_cnt;

  task automatic checkField(input string tag, input string field,
                            input logic [31:0] got, input logic [31:0] want);
    n_vectors++;
    assert (got === want) else begin
      n_miss++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, got, want);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkField(tag, "wb_wreg",       {31'd0, bus_if.wb_wreg},  {31'd0, exp_wreg});
    checkField(tag, "wb_wd",         {27'd0, bus_if.wb_wd},    {27'd0, exp_wd});
    checkField(tag, "wb_wdata",      bus_if.wb_wdata,          exp_wdata);
    checkField(tag, "wb_ade",        {31'd0, bus_if.wb_ade},   {31'd0, exp_ade});
    checkField(tag, "wb_retire_cnt", bus_if.wb_retire_cnt,     exp_cnt);
  endtask

  // Reference: load = n-byte field at byte offset off of a big-endian word.
  task automatic modelStep();
    int          nbytes;
    bit          sext;
    bit          known;
    int          off;
    logic [31:0] mask;
    logic [31:0] val;
    if (rst) begin
      exp_wreg = 0; exp_wd = 0; exp_wdata = 0; exp_ade = 0; exp_cnt = 0;
    end else if (bus_if.flush || (bus_if.stall_mem && !bus_if.stall_wb)) begin
      exp_wreg = 0; exp_wd = 0; exp_wdata = 0; exp_ade = 0;
    end else if (bus_if.stall_mem && bus_if.stall_wb) begin
      exp_ade = 0;
    end else if (!bus_if.mem_valid) begin
      exp_wreg = 0; exp_wd = 0; exp_wdata = 0; exp_ade = 0;
    end else begin
      exp_cnt = exp_cnt + 1;
      exp_wd  = bus_if.mem_wd;
      exp_ade = 0;
      if (!bus_if.mem_is_load) begin
        exp_wreg  = bus_if.mem_wreg;
        exp_wdata = bus_if.mem_wdata;
      end else begin
        known = 1; nbytes = 4; sext = 0;
        case (bus_if.mem_load_op)
          3'd0:    begin nbytes = 4; sext = 0; end
          3'd1:    begin nbytes = 2; sext = 1; end
          3'd2:    begin nbytes = 2; sext = 0; end
          3'd3:    begin nbytes = 1; sext = 1; end
          3'd4:    begin nbytes = 1; sext = 0; end
          default: known = 0;
        endcase
        off = int'(bus_if.mem_addr_lo);
        if (!known || (off % nbytes) != 0) begin
          exp_wreg = 0; exp_wdata = 0; exp_ade = 1;
        end else begin
          mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
          val  = (bus_if.mem_rdata >> (8 * (4 - nbytes - off))) & mask;
          if (sext && val[8 * nbytes - 1]) val = val | ~mask;
          exp_wreg  = bus_if.mem_wreg;
          exp_wdata = val;
        end
      end
    end
  endtask

  task automatic applyStimulus(input string tag);
    modelStep();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic setCtl(input logic r, input logic sm, input logic sw, input logic fl);
    rst = r;
    bus_if.stall_mem = sm;
    bus_if.stall_wb  = sw;
    bus_if.flush     = fl;
  endtask

  task automatic setMem(input logic v, input logic wr, input logic [4:0] wd,
                        input logic [31:0] wdata, input logic ld, input logic [2:0] op,
                        input logic [1:0] lo, input logic [31:0] rdata);
    bus_if.mem_valid   = v;
    bus_if.mem_wreg    = wr;
    bus_if.mem_wd      = wd;
    bus_if.mem_wdata   = wdata;
    bus_if.mem_is_load = ld;
    bus_if.mem_load_op = op;
    bus_if.mem_addr_lo = lo;
    bus_if.mem_rdata   = rdata;
  endtask

  localparam logic [31:0] RD = 32'h80FF_7F01;

  initial begin
    n_vectors = 0;
    n_miss    = 0;
    exp_wreg = 0; exp_wd = 0; exp_wdata = 0; exp_ade = 0; exp_cnt = 0;
    setCtl(1, 0, 0, 0);
    setMem(1, 1, 5'd9, 32'hDEAD_BEEF, 0, 3'd0, 2'd0, 32'd0);
    applyStimulus("reset0");
    applyStimulus("reset1");

    setCtl(0, 0, 0, 0);
    setMem(1, 1, 5'd5, 32'h1234_5678, 0, 3'd0, 2'd0, 32'd0);
    applyStimulus("nonload");

    setMem(1, 1, 5'd6, 32'h0, 1, 3'd3, 2'b00, RD); applyStimulus("lb_00");
    setMem(1, 1, 5'd7, 32'h0, 1, 3'd4, 2'b00, RD); applyStimulus("lbu_00");
    setMem(1, 1, 5'd8, 32'h0, 1, 3'd3, 2'b10, RD); applyStimulus("lb_10");
    setMem(1, 1, 5'd9, 32'h0, 1, 3'd1, 2'b10, RD); applyStimulus("lh_10");
    setMem(1, 1, 5'd10, 32'h0, 1, 3'd2, 2'b00, RD); applyStimulus("lhu_00");
    setMem(1, 1, 5'd11, 32'h0, 1, 3'd0, 2'b00, RD); applyStimulus("lw_00");
    setMem(1, 1, 5'd0, 32'h0, 1, 3'd4, 2'b11, RD); applyStimulus("lbu_11_r0");

    setMem(1, 1, 5'd12, 32'h0, 1, 3'd0, 2'b01, RD); applyStimulus("lw_01_ade");
    setMem(1, 1, 5'd13, 32'h0, 1, 3'd1, 2'b11, RD); applyStimulus("lh_11_ade");
    setMem(1, 1, 5'd14, 32'h0, 1, 3'd7, 2'b00, RD); applyStimulus("op111_ade");
    setCtl(0, 1, 1, 0);
    applyStimulus("ade_no_repeat_hold");
    setCtl(0, 0, 0, 0);
    setMem(1, 1, 5'd15, 32'hAAAA_5555, 0, 3'd0, 2'd0, RD);
    applyStimulus("after_ade");

    setCtl(0, 1, 0, 0); applyStimulus("stall_mem_bubble");
    setCtl(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus("both_stalled");

    setCtl(0, 0, 1, 0);
    setMem(1, 1, 5'd3, 32'h0BAD_F00D, 0, 3'd0, 2'd0, RD);
    applyStimulus("stall_wb_only_capture");
    setCtl(0, 1, 1, 0); applyStimulus("hold_valid");
    setCtl(0, 1, 1, 1); applyStimulus("flush_over_stall");
    setCtl(0, 0, 0, 0); applyStimulus("refill");
    setCtl(0, 1, 1, 0); applyStimulus("hold_again");
    setCtl(1, 1, 1, 0); applyStimulus("reset_in_hold");
    setCtl(0, 0, 0, 0); applyStimulus("first_after_reset");

    for (int i = 0; i < 300; i++) begin
      setCtl(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      setMem(($urandom_range(0, 5) != 0), 1'($urandom), 5'($urandom), $urandom,
             1'($urandom), 3'($urandom_range(0, 5) == 5 ? $urandom_range(5, 7) : $urandom_range(0, 4)),
             2'($urandom), $urandom);
      applyStimulus("random");
    end

    setCtl(0, 1, 1, 0);
    applyStimulus("pre_wrap_hold");
    force dut.retire_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.retire_cnt;
    exp_cnt = 32'hFFFF_FFFE;
    setCtl(0, 0, 0, 0);
    setMem(1, 1, 5'd1, 32'h1, 0, 3'd0, 2'd0, 32'd0);
    applyStimulus("cnt_ffffffff");
    applyStimulus("cnt_wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miss);
    $finish;
  end

endmodule
